// File: rtl/scan_mc_pkg.sv
// Shared types and constants for the multi-chain scan controller.
// Holds the FSM state enum, per-word shift count K and mode encodings.
package scan_mc_pkg;

    localparam int NUM_CHAINS_D = 4;
    localparam int WORD_W_D     = 32;
    localparam int LEN_W_D      = 16;

    // Shifts per FIFO word and the counter width that can hold 0..K.
    localparam int K           = WORD_W_D / NUM_CHAINS_D;
    localparam int SHIFT_CNT_W = $clog2(K + 1);

    localparam logic MODE_LOAD    = 1'b0;
    localparam logic MODE_CAPTURE = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_SHIFT,
        S_STORE,
        S_FIN
    } state_t;

    function automatic int shift_cnt_w(input int k);
        return $clog2(k + 1);
    endfunction

endpackage

// File: rtl/scan_word_serdes.sv
// Word shift register between FIFO words and NUM_CHAINS serial lanes.
// Ports: clk/rst, i_load/i_load_data (parallel load), i_shift,
//   i_ser_in (inserted at top), o_ser_out (low lanes), i_nshift
//   (shifts done this word), o_word (captured word, right-aligned).
module scan_word_serdes #(
    parameter int NUM_CHAINS = 4,
    parameter int WORD_W     = 32,
    parameter int CW         = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic [WORD_W-1:0]     i_load_data,
    input  logic                  i_shift,
    input  logic [NUM_CHAINS-1:0] i_ser_in,
    output logic [NUM_CHAINS-1:0] o_ser_out,
    input  logic [CW-1:0]         i_nshift,
    output logic [WORD_W-1:0]     o_word
);

    localparam int KW = WORD_W / NUM_CHAINS;

    logic [WORD_W-1:0] r_sh;
    logic [WORD_W-1:0] w_shifted;
    int                w_gap;

    generate
        if (NUM_CHAINS == WORD_W) begin : g_full
            assign w_shifted = i_ser_in;
        end else begin : g_part
            assign w_shifted = {i_ser_in, r_sh[WORD_W-1:NUM_CHAINS]};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sh <= '0;
        end else if (i_load) begin
            r_sh <= i_load_data;
        end else if (i_shift) begin
            r_sh <= w_shifted;
        end
    end

    assign o_ser_out = r_sh[NUM_CHAINS-1:0];

    // A short word has its captures sitting at the top; slide them
    // down by the missing shifts so leftover input bits fall off.
    always_comb begin
        w_gap  = KW - int'(i_nshift);
        o_word = r_sh >> (w_gap * NUM_CHAINS);
    end

endmodule

// File: rtl/scan_chain_ctrl_mc.sv
// Multi-chain scan controller: unpacks input-FIFO words onto NUM_CHAINS
// scan chains and packs captured bits back into the output FIFO.
// Ports: aclk/areset; start/length/mode in, busy/done out;
//   in_data/in_empty/in_rd_en (input FIFO); out_data/out_almost_full/
//   out_wr_en (output FIFO); scan_in/scan_out/scan_enable/scan_ck_enable.
// Build option SCAN_ROTATE_EN: mode=1 feeds scan_out back to scan_in so
//   a capture-only run leaves chain contents intact.
module scan_chain_ctrl_mc
    import scan_mc_pkg::*;
#(
    parameter int NUM_CHAINS = NUM_CHAINS_D,
    parameter int WORD_W     = NUM_CHAINS_D * K,
    parameter int LEN_W      = LEN_W_D
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  start,
    input  logic [LEN_W-1:0]      length,
    input  logic                  mode,
    output logic                  busy,
    output logic                  done,
    input  logic [WORD_W-1:0]     in_data,
    input  logic                  in_empty,
    output logic                  in_rd_en,
    output logic [WORD_W-1:0]     out_data,
    input  logic                  out_almost_full,
    output logic                  out_wr_en,
    output logic [NUM_CHAINS-1:0] scan_in,
    input  logic [NUM_CHAINS-1:0] scan_out,
    output logic                  scan_enable,
    output logic                  scan_ck_enable
);

    localparam int KW = WORD_W / NUM_CHAINS;
    localparam int CW = (KW == K) ? SHIFT_CNT_W : shift_cnt_w(KW);

    state_t            r_state, w_state_nxt;
    logic [LEN_W-1:0]  r_rem, w_rem_nxt;
    logic [CW-1:0]     r_cnt, w_cnt_nxt;
    logic              r_mode, w_mode_nxt;
    logic              r_busy, w_busy_nxt;
    logic              r_done, w_done_nxt;

    logic              w_load;
    logic [WORD_W-1:0] w_load_data;
    logic              w_shift;
    logic [NUM_CHAINS-1:0] w_ser_out;
    logic [WORD_W-1:0] w_word;
    logic              w_rot;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state <= S_IDLE;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_mode  <= MODE_LOAD;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
            r_cnt   <= w_cnt_nxt;
            r_mode  <= w_mode_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_rem_nxt      = r_rem;
        w_cnt_nxt      = r_cnt;
        w_mode_nxt     = r_mode;
        w_busy_nxt     = r_busy;
        w_done_nxt     = r_done;
        w_load         = 1'b0;
        w_load_data    = '0;
        w_shift        = 1'b0;
        in_rd_en       = 1'b0;
        out_wr_en      = 1'b0;
        scan_enable    = 1'b0;
        scan_ck_enable = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_busy_nxt = 1'b1;
                    w_done_nxt = 1'b0;
                    w_mode_nxt = mode;
                    w_rem_nxt  = length;
                    w_cnt_nxt  = '0;
                    if (length == '0) begin
                        w_state_nxt = S_FIN;
                    end else if (mode == MODE_CAPTURE) begin
                        w_load      = 1'b1;
                        w_state_nxt = S_SHIFT;
                    end else begin
                        w_state_nxt = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                if (!in_empty) begin
                    in_rd_en    = 1'b1;
                    w_state_nxt = S_LATCH;
                end
            end
            S_LATCH: begin
                w_load      = 1'b1;
                w_load_data = in_data;
                w_state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                scan_enable = 1'b1;
                if (!out_almost_full) begin
                    scan_ck_enable = 1'b1;
                    w_shift        = 1'b1;
                    w_rem_nxt      = r_rem - LEN_W'(1);
                    w_cnt_nxt      = r_cnt + CW'(1);
                    if (r_cnt == CW'(KW - 1) || r_rem == LEN_W'(1)) begin
                        w_state_nxt = S_STORE;
                    end
                end
            end
            S_STORE: begin
                out_wr_en = 1'b1;
                w_cnt_nxt = '0;
                if (r_rem != '0) begin
                    if (r_mode == MODE_CAPTURE) begin
                        w_load      = 1'b1;
                        w_state_nxt = S_SHIFT;
                    end else begin
                        w_state_nxt = S_FETCH;
                    end
                end else begin
                    // done lands in the cycle right after the last write
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = S_FIN;
                end
            end
            S_FIN: begin
                w_done_nxt  = 1'b1;
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

`ifdef SCAN_ROTATE_EN
    assign w_rot = (r_mode == MODE_CAPTURE);
`else
    assign w_rot = 1'b0;
`endif

    scan_word_serdes #(
        .NUM_CHAINS (NUM_CHAINS),
        .WORD_W     (WORD_W),
        .CW         (CW)
    ) u_serdes (
        .clk         (aclk),
        .rst         (areset),
        .i_load      (w_load),
        .i_load_data (w_load_data),
        .i_shift     (w_shift),
        .i_ser_in    (scan_out),
        .o_ser_out   (w_ser_out),
        .i_nshift    (r_cnt),
        .o_word      (w_word)
    );

    assign scan_in  = (r_state != S_SHIFT) ? '0 :
                      (w_rot ? scan_out : w_ser_out);
    assign out_data = (r_state == S_STORE) ? w_word : '0;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

// File: tb/tb_scan_chain_ctrl_mc.sv
// Directed bench for scan_chain_ctrl_mc with FIFO and 8-bit chain models.
// Expected words are hand-computed from the chain contents.
module tb_scan_chain_ctrl_mc;

    logic        clk = 1'b0;
    logic        areset;
    logic        start;
    logic [15:0] length;
    logic        mode;
    logic        busy;
    logic        done;
    logic [31:0] in_data;
    logic        in_empty;
    logic        in_rd_en;
    logic [31:0] out_data;
    logic        af;
    logic        out_wr_en;
    logic [3:0]  scan_in;
    logic [3:0]  scan_out;
    logic        scan_enable;
    logic        scan_ck_enable;

    int n_tests = 0;
    int n_fail  = 0;

    // input FIFO model
    logic [31:0] mem [16];
    int          wp = 0;
    int          rp = 0;
    logic        flush;

    // statistics
    logic        clr;
    int          n_rd, n_wr, n_ck, n_stall, owp;
    logic [31:0] out_mem [8];
    logic [3:0]  first_si, last_si;

    // chain model: 8 cells per chain
    logic [7:0]  ch [4];
    logic        ch_ld;
    logic [7:0]  ch_pre;

    logic [41:0] outs;
    logic [31:0] exp_rot2;

    always #5 clk = ~clk;

    scan_chain_ctrl_mc #(
        .NUM_CHAINS (4),
        .WORD_W     (32),
        .LEN_W      (16)
    ) dut (
        .aclk            (clk),
        .areset          (areset),
        .start           (start),
        .length          (length),
        .mode            (mode),
        .busy            (busy),
        .done            (done),
        .in_data         (in_data),
        .in_empty        (in_empty),
        .in_rd_en        (in_rd_en),
        .out_data        (out_data),
        .out_almost_full (af),
        .out_wr_en       (out_wr_en),
        .scan_in         (scan_in),
        .scan_out        (scan_out),
        .scan_enable     (scan_enable),
        .scan_ck_enable  (scan_ck_enable)
    );

    assign in_empty = (rp == wp);
    assign outs = {busy, done, in_rd_en, out_wr_en, scan_enable,
                   scan_ck_enable, scan_in, out_data};

    always @(posedge clk) begin
        if (in_rd_en) in_data <= mem[rp % 16];
        if (flush) rp <= wp;
        else if (in_rd_en) rp <= rp + 1;
        if (clr) begin
            n_rd <= 0; n_wr <= 0; n_ck <= 0; n_stall <= 0; owp <= 0;
        end else begin
            if (in_rd_en) n_rd <= n_rd + 1;
            if (out_wr_en) begin
                out_mem[owp % 8] <= out_data;
                owp  <= owp + 1;
                n_wr <= n_wr + 1;
            end
            if (scan_ck_enable) begin
                if (n_ck == 0) first_si <= scan_in;
                last_si <= scan_in;
                n_ck <= n_ck + 1;
            end
            if (scan_enable && !scan_ck_enable) n_stall <= n_stall + 1;
        end
    end

    always @(posedge clk) begin
        if (ch_ld) begin
            for (int c = 0; c < 4; c++) ch[c] <= ch_pre;
        end else if (scan_ck_enable) begin
            for (int c = 0; c < 4; c++) ch[c] <= {ch[c][6:0], scan_in[c]};
        end
    end

    always_comb begin
        for (int c = 0; c < 4; c++) scan_out[c] = ch[c][7];
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_stats(input bit ld, input logic [7:0] pre);
        @(negedge clk);
        clr = 1'b1; flush = 1'b1; ch_ld = ld; ch_pre = pre;
        @(negedge clk);
        clr = 1'b0; flush = 1'b0; ch_ld = 1'b0;
    endtask

    task automatic push(input logic [31:0] w);
        mem[wp % 16] = w;
        wp = wp + 1;
    endtask

    // returns at the negedge of the cycle after start was sampled
    task automatic go(input logic [15:0] len, input logic md);
        @(negedge clk);
        length = len; mode = md; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int i;
        i = 0;
        while (!done && i < 300) begin
            @(negedge clk);
            i++;
        end
        chk(tag, 64'(done), 64'd1);
    endtask

    initial begin
        int w;
        areset = 1'b1; start = 1'b0; length = '0; mode = 1'b0; af = 1'b0;
        clr = 1'b0; flush = 1'b0; ch_ld = 1'b0; ch_pre = '0;
`ifdef SCAN_ROTATE_EN
        exp_rot2 = 32'hF0F0_0F0F;
`else
        exp_rot2 = 32'h0000_0000;
`endif
        repeat (2) @(negedge clk);
        chk("reset_outs", 64'(outs), 64'd0);
        areset = 1'b0;
        @(negedge clk);
        chk("idle_outs", 64'(outs), 64'd0);

        // single word, chains start empty
        clear_stats(1'b1, 8'h00);
        push(32'h8765_4321);
        go(16'd8, 1'b0);
        chk("t1_rd_at_T1", 64'(in_rd_en), 64'd1);
        chk("t1_ck_at_T1", 64'(scan_ck_enable), 64'd0);
        @(negedge clk);
        chk("t1_ck_at_T2", 64'(scan_ck_enable), 64'd0);
        @(negedge clk);
        chk("t1_ck_at_T3", 64'(scan_ck_enable), 64'd1);
        wait_done("t1_done");
        chk("t1_first_si", 64'(first_si), 64'h1);
        chk("t1_last_si", 64'(last_si), 64'h8);
        chk("t1_n_wr", 64'(n_wr), 64'd1);
        chk("t1_n_rd", 64'(n_rd), 64'd1);
        chk("t1_n_ck", 64'(n_ck), 64'd8);
        chk("t1_word", 64'(out_mem[0]), 64'h0);

        // three words, partial last word
        clear_stats(1'b1, 8'h00);
        push(32'hDEAD_BEEF);
        push(32'h1234_5678);
        push(32'hCAFE_F00D);
        go(16'd20, 1'b0);
        w = 0;
        for (int i = 0; i < 300 && w < 3; i++) begin
            if (out_wr_en) w++;
            if (w < 3) @(negedge clk);
        end
        chk("t2_wr_seen", 64'(w), 64'd3);
        chk("t2_done_on_wr", 64'(done), 64'd0);
        @(negedge clk);
        chk("t2_done_after", 64'(done), 64'd1);
        chk("t2_busy_after", 64'(busy), 64'd0);
        chk("t2_n_rd", 64'(n_rd), 64'd3);
        chk("t2_n_wr", 64'(n_wr), 64'd3);
        chk("t2_n_ck", 64'(n_ck), 64'd20);
        chk("t2_word0", 64'(out_mem[0]), 64'h0);
        chk("t2_word1", 64'(out_mem[1]), 64'hDEAD_BEEF);
        chk("t2_word2", 64'(out_mem[2]), 64'h0000_5678);

        // output FIFO back-pressure for 5 cycles
        clear_stats(1'b1, 8'hA5);
        push(32'h0000_0000);
        go(16'd8, 1'b0);
        for (int i = 0; i < 100 && n_ck < 3; i++) @(negedge clk);
        chk("t3_reach", 64'(n_ck), 64'd3);
        af = 1'b1;
        repeat (5) @(negedge clk);
        af = 1'b0;
        wait_done("t3_done");
        chk("t3_n_stall", 64'(n_stall), 64'd5);
        chk("t3_n_ck", 64'(n_ck), 64'd8);
        chk("t3_n_wr", 64'(n_wr), 64'd1);
        chk("t3_word", 64'(out_mem[0]), 64'hF0F0_0F0F);

        // zero length
        clear_stats(1'b1, 8'h00);
        go(16'd0, 1'b0);
        chk("t4_done_T1", 64'(done), 64'd0);
        chk("t4_busy_T1", 64'(busy), 64'd1);
        @(negedge clk);
        chk("t4_done_T2", 64'(done), 64'd1);
        chk("t4_busy_T2", 64'(busy), 64'd0);
        chk("t4_activity", {n_rd[15:0], n_wr[15:0], n_ck[15:0]}, 64'd0);

        // reset during the second word
        clear_stats(1'b1, 8'h00);
        push(32'h1111_1111);
        push(32'h2222_2222);
        push(32'h3333_3333);
        go(16'd20, 1'b0);
        for (int i = 0; i < 200 && !(n_wr >= 1 && n_ck >= 10); i++)
            @(negedge clk);
        chk("t5_reach", 64'(n_wr >= 1 && n_ck >= 10), 64'd1);
        areset = 1'b1;
        @(negedge clk);
        chk("t5_rst_outs", 64'(outs), 64'd0);
        areset = 1'b0;
        repeat (3) @(negedge clk);
        chk("t5_no_strobes", {32'(n_rd), 32'(n_wr)}, {32'd2, 32'd1});
        clear_stats(1'b1, 8'hA5);
        push(32'h0000_0000);
        go(16'd8, 1'b0);
        wait_done("t5_rerun_done");
        chk("t5_rerun_cnt", {32'(n_rd), 32'(n_wr)}, {32'd1, 32'd1});
        chk("t5_rerun_word", 64'(out_mem[0]), 64'hF0F0_0F0F);

        // capture-only (rotate readout when SCAN_ROTATE_EN)
        clear_stats(1'b1, 8'hA5);
        go(16'd8, 1'b1);
        wait_done("t6_done1");
        chk("t6_word1", 64'(out_mem[0]), 64'hF0F0_0F0F);
        chk("t6_n_rd1", 64'(n_rd), 64'd0);
        chk("t6_n_ck1", 64'(n_ck), 64'd8);
        clear_stats(1'b0, 8'h00);
        go(16'd8, 1'b1);
        wait_done("t6_done2");
        chk("t6_word2", 64'(out_mem[0]), 64'(exp_rot2));
        chk("t6_n_rd2", 64'(n_rd), 64'd0);
        chk("t6_n_wr2", 64'(n_wr), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
